// File: rtl/multi_dataflow_job_fsm_pkg.sv
// Shared types for the multi_dataflow job sequencer: FSM state encoding and
// the per-job configuration latched at start.
package multi_dataflow_job_fsm_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ITER_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_SINK,
    S_START_SRC,
    S_COMPUTE,
    S_UPDATE,
    S_DONE
  } job_state_e;

  // in_base/out_base hold the current iteration's addresses once a job runs
  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [LEN_W-1:0]  len;
    logic [ITER_W-1:0] n_iter;
    logic [ADDR_W-1:0] stride;
  } job_cfg_t;

endpackage

// File: rtl/multi_dataflow_job_fsm.sv
// Job sequencer: starts sink, then source+engine, waits for all three dones, strides addresses per iteration.
// Start pulses are combinational on ready (ready low stalls); done_o follows the last done pulse by two cycles.
module multi_dataflow_job_fsm
  import multi_dataflow_job_fsm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned LEN_WIDTH  = LEN_W,
  parameter int unsigned ITER_WIDTH = ITER_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_base_i,
  input  logic [ADDR_WIDTH-1:0] out_base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ITER_WIDTH-1:0] n_iter_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic                  src_ready_i,
  input  logic                  sink_ready_i,
  input  logic                  src_done_i,
  input  logic                  sink_done_i,
  input  logic                  eng_done_i,
  output logic                  src_start_o,
  output logic                  sink_start_o,
  output logic                  eng_start_o,
  output logic [ADDR_WIDTH-1:0] src_addr_o,
  output logic [ADDR_WIDTH-1:0] sink_addr_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  output logic [ITER_WIDTH-1:0] iter_o,
  output logic                  busy_o,
  output logic                  done_o
);

  job_state_e            state_q, state_d;
  job_cfg_t              cfg_q, cfg_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [2:0]            sticky_q, sticky_d;  // {src, sink, eng}

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      iter_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      iter_q   <= iter_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    iter_d       = iter_q;
    sticky_d     = sticky_q;
    sink_start_o = 1'b0;
    src_start_o  = 1'b0;
    eng_start_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_d.in_base  = in_base_i;
          cfg_d.out_base = out_base_i;
          cfg_d.len      = len_i;
          cfg_d.n_iter   = n_iter_i;
          cfg_d.stride   = stride_i;
          iter_d         = '0;
          state_d        = (len_i == '0 || n_iter_i == '0) ? S_DONE : S_START_SINK;
        end
      end
      S_START_SINK: begin
        sink_start_o = sink_ready_i;
        if (sink_ready_i) state_d = S_START_SRC;
      end
      S_START_SRC: begin
        src_start_o = src_ready_i;
        eng_start_o = src_ready_i;
        if (src_ready_i) begin
          sticky_d = '0;
          state_d  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        sticky_d = sticky_q | {src_done_i, sink_done_i, eng_done_i};
        if (&sticky_d) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (iter_q + ITER_WIDTH'(1) == cfg_q.n_iter) begin
          state_d = S_DONE;
        end else begin
          iter_d         = iter_q + ITER_WIDTH'(1);
          cfg_d.in_base  = cfg_q.in_base + cfg_q.stride;
          cfg_d.out_base = cfg_q.out_base + cfg_q.stride;
          state_d        = S_START_SINK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // soft clear overrides everything, including a same-cycle start
    if (clear_i) begin
      state_d  = S_IDLE;
      sticky_d = '0;
      iter_d   = '0;
    end
  end

  assign src_addr_o  = cfg_q.in_base;
  assign sink_addr_o = cfg_q.out_base;
  assign len_o       = cfg_q.len;
  assign iter_o      = iter_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_multi_dataflow_job_fsm.sv
// Directed bench for the job sequencer; expected values are hand-computed.
module tb_multi_dataflow_job_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0, start = 1'b0;
  logic [31:0] in_base = '0, out_base = '0, stride = '0;
  logic [15:0] len = '0;
  logic [7:0]  n_iter = '0;
  logic        src_rdy = 1'b1, sink_rdy = 1'b1;
  logic        src_done = 1'b0, sink_done = 1'b0, eng_done = 1'b0;
  logic        src_start, sink_start, eng_start, busy, done;
  logic [31:0] src_addr, sink_addr;
  logic [15:0] len_o;
  logic [7:0]  iter;

  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_sink_st = 0, n_src_st = 0, n_eng_st = 0;
  int d0, s0, r0, e0;

  always #5 clk = ~clk;

  multi_dataflow_job_fsm dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .in_base_i(in_base), .out_base_i(out_base), .len_i(len),
    .n_iter_i(n_iter), .stride_i(stride),
    .src_ready_i(src_rdy), .sink_ready_i(sink_rdy),
    .src_done_i(src_done), .sink_done_i(sink_done), .eng_done_i(eng_done),
    .src_start_o(src_start), .sink_start_o(sink_start), .eng_start_o(eng_start),
    .src_addr_o(src_addr), .sink_addr_o(sink_addr), .len_o(len_o),
    .iter_o(iter), .busy_o(busy), .done_o(done)
  );

  always @(posedge clk) begin
    if (done)       n_done++;
    if (sink_start) n_sink_st++;
    if (src_start)  n_src_st++;
    if (eng_start)  n_eng_st++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    d0 = n_done; s0 = n_sink_st; r0 = n_src_st; e0 = n_eng_st;
  endtask

  task automatic launch(input logic [31:0] ib, input logic [31:0] ob, input logic [15:0] l,
                        input logic [7:0] n, input logic [31:0] st);
    in_base = ib; out_base = ob; len = l; n_iter = n; stride = st;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From START_SINK: run one iteration with simultaneous dones, end at next START_SINK/DONE
  task automatic one_iter();
    tick();
    tick();
    {src_done, sink_done, eng_done} = 3'b111;
    tick();
    {src_done, sink_done, eng_done} = 3'b000;
    tick();
  endtask

  logic [31:0] exp_src [3] = '{32'h1000, 32'h1100, 32'h1200};
  logic [31:0] exp_snk [3] = '{32'h2000, 32'h2100, 32'h2200};

  initial begin
    // reset
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_starts", {sink_start, src_start, eng_start}, 0);
    check_eq("rst_src_addr", src_addr, 0);
    check_eq("rst_len", len_o, 0);
    check_eq("rst_iter", iter, 0);
    rst = 1'b0;
    tick();

    // T1: single iteration, dones src, sink, eng on consecutive cycles
    snap();
    launch(32'h1000, 32'h2000, 16'd64, 8'd1, 32'h0);
    check_eq("t1_sink_start_c1", sink_start, 1);
    check_eq("t1_src_start_c1", src_start, 0);
    check_eq("t1_busy_c1", busy, 1);
    check_eq("t1_len", len_o, 64);
    check_eq("t1_src_addr", src_addr, 32'h1000);
    check_eq("t1_sink_addr", sink_addr, 32'h2000);
    tick();
    check_eq("t1_src_eng_start_c2", {src_start, eng_start, sink_start}, 3'b110);
    tick();
    src_done = 1'b1; tick();
    src_done = 1'b0; sink_done = 1'b1; tick();
    sink_done = 1'b0; eng_done = 1'b1; tick();
    eng_done = 1'b0;
    check_eq("t1_update_no_done", done, 0);
    tick();
    check_eq("t1_done_t2", done, 1);
    tick();
    check_eq("t1_done_one_cycle", done, 0);
    check_eq("t1_idle", busy, 0);

    // T2: three iterations, dones eng, sink, src; start while busy ignored
    snap();
    launch(32'h1000, 32'h2000, 16'd64, 8'd3, 32'h100);
    for (int it = 0; it < 3; it++) begin
      check_eq($sformatf("t2_sink_start_%0d", it), sink_start, 1);
      check_eq($sformatf("t2_src_addr_%0d", it), src_addr, exp_src[it]);
      check_eq($sformatf("t2_sink_addr_%0d", it), sink_addr, exp_snk[it]);
      check_eq($sformatf("t2_iter_%0d", it), iter, it);
      tick();
      check_eq($sformatf("t2_src_start_%0d", it), src_start, 1);
      if (it == 0) begin
        start = 1'b1; in_base = 32'hDEAD0000; len = 16'd7;
      end
      tick();
      start = 1'b0;
      eng_done = 1'b1; tick();
      eng_done = 1'b0; sink_done = 1'b1; tick();
      sink_done = 1'b0; src_done = 1'b1; tick();
      src_done = 1'b0;
      check_eq($sformatf("t2_update_%0d", it), {busy, done}, 2'b10);
      tick();
    end
    check_eq("t2_done", done, 1);
    check_eq("t2_len_held", len_o, 64);
    tick();
    check_eq("t2_idle", busy, 0);
    check_eq("t2_done_count", n_done - d0, 1);
    check_eq("t2_sink_count", n_sink_st - s0, 3);

    // T3: sink_ready low 5 cycles, then all dones in the same cycle
    snap();
    sink_rdy = 1'b0;
    launch(32'h1000, 32'h2000, 16'd8, 8'd1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3_stall_%0d", i), {sink_start, src_start, eng_start}, 0);
      tick();
    end
    sink_rdy = 1'b1;
    #1;
    check_eq("t3_sink_start_c6", sink_start, 1);
    tick();
    check_eq("t3_src_start_c7", src_start, 1);
    tick();
    {src_done, sink_done, eng_done} = 3'b111;
    tick();
    {src_done, sink_done, eng_done} = 3'b000;
    check_eq("t3_update", {busy, done}, 2'b10);
    tick();
    check_eq("t3_done", done, 1);
    tick();
    check_eq("t3_src_count", n_src_st - r0, 1);
    check_eq("t3_eng_count", n_eng_st - e0, 1);

    // T4: zero length, then zero iterations; start held into DONE is ignored
    snap();
    in_base = 32'h40; out_base = 32'h80; len = 16'd0; n_iter = 8'd1;
    start = 1'b1;
    tick();
    check_eq("t4_len0_done_c1", {busy, done}, 2'b11);
    tick();
    start = 1'b0;
    check_eq("t4_len0_c2", {busy, done}, 2'b00);
    tick();
    check_eq("t4_len0_c3", busy, 0);
    launch(32'h40, 32'h80, 16'd5, 8'd0, 32'h0);
    check_eq("t4_n0_done_c1", {busy, done}, 2'b11);
    tick();
    check_eq("t4_n0_c2", {busy, done}, 2'b00);
    check_eq("t4_no_starts", (n_sink_st - s0) + (n_src_st - r0) + (n_eng_st - e0), 0);
    check_eq("t4_done_count", n_done - d0, 2);

    // T5: address wrap
    launch(32'hFFFFFF00, 32'h3000, 16'd4, 8'd2, 32'h100);
    check_eq("t5_src_addr0", src_addr, 32'hFFFFFF00);
    one_iter();
    check_eq("t5_src_addr_wrap", src_addr, 32'h0);
    check_eq("t5_sink_addr1", sink_addr, 32'h3100);
    check_eq("t5_iter1", iter, 1);
    one_iter();
    check_eq("t5_done", done, 1);
    tick();

    // T6: clear in COMPUTE, clear beats start, reset mid-job
    snap();
    launch(32'h1000, 32'h2000, 16'd4, 8'd2, 32'h0);
    tick(); tick();
    clear = 1'b1; src_done = 1'b1;
    tick();
    clear = 1'b0; src_done = 1'b0;
    check_eq("t6_clear_idle", busy, 0);
    check_eq("t6_clear_iter", iter, 0);
    tick(); tick();
    check_eq("t6_clear_no_done", n_done - d0, 0);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check_eq("t6_clear_beats_start", busy, 0);

    launch(32'h1000, 32'h2000, 16'd4, 8'd3, 32'h40);
    one_iter();
    check_eq("t6_iter1", iter, 1);
    check_eq("t6_src_addr1", src_addr, 32'h1040);
    tick();
    snap();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_starts", {sink_start, src_start, eng_start}, 0);
    check_eq("t6_rst_addrs", src_addr | sink_addr, 0);
    check_eq("t6_rst_iter", iter, 0);
    check_eq("t6_rst_len", len_o, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t6_post_rst_quiet",
             (n_sink_st - s0) + (n_src_st - r0) + (n_eng_st - e0) + (n_done - d0), 0);
    check_eq("t6_post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
